// File: rtl/system_pll_reset_sequencer.sv
// System PLL reset/lock sequencer: PLL reset pulse, lock wait with bounded retries,
// lock-stability qualification, then release of sys_reset_n.
// Optional RUN loss-of-lock counter is built only when SYSTEM_PLL_LOSS_COUNTER_EN is defined.
`timescale 1ns/1ps
module system_pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic [2:0] state,
  output logic [3:0] retry_count
`ifdef SYSTEM_PLL_LOSS_COUNTER_EN
  ,
  output logic [7:0] loss_count
`endif
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             lock_meta, locked_s;
  logic             loss_event;

  // Two-flop synchronizer: pll_locked is asynchronous to the refclk domain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    loss_event = 1'b0;
    if (soft_reset_req) begin
      state_d = RESET_PLL;
      retry_d = 4'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        WAIT_LOCK: begin
          // Lock beats a coincident timeout.
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_LIMIT) begin
              state_d = FAIL;
            end else begin
              state_d = RESET_PLL;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s)                 state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = RUN;
          else                           cnt_d   = cnt_q + 1'b1;
        end
        RUN: begin
          if (!locked_s) begin
            state_d    = RESET_PLL;
            retry_d    = 4'd0;
            loss_event = 1'b1;
          end
        end
        FAIL:    state_d = FAIL;
        default: state_d = RESET_PLL;
      endcase
      if (state_d != state_q) cnt_d = '0;
    end
  end

  // Outputs are decoded from state_d so they switch on the same edge as state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      pll_ready   <= 1'b0;
      pll_fail    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst     <= (state_d == RESET_PLL) || (state_d == FAIL);
      sys_reset_n <= (state_d == RUN);
      pll_ready   <= (state_d == RUN);
      pll_fail    <= (state_d == FAIL);
    end
  end

`ifdef SYSTEM_PLL_LOSS_COUNTER_EN
  logic [7:0] loss_q;

  always_ff @(posedge clk) begin
    if (!reset_n)                        loss_q <= 8'd0;
    else if (loss_event && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
  end

  assign loss_count = loss_q;
`else
  logic unused_loss;
  assign unused_loss = loss_event;
`endif

  assign state       = state_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_system_pll_reset_sequencer.sv
// Directed bench for system_pll_reset_sequencer with small parameters (4/8/32/2);
// expected values are hand-computed edge counts. Loss counter checked when SYSTEM_PLL_LOSS_COUNTER_EN is defined.
`timescale 1ns/1ps
module tb_system_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       pll_ready;
  logic       pll_fail;
  logic [2:0] state;
  logic [3:0] retry_count;
`ifdef SYSTEM_PLL_LOSS_COUNTER_EN
  logic [7:0] loss_count;
`endif

  int errors = 0;
  int checks = 0;

  system_pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .soft_reset_req(soft_reset_req),
    .pll_rst(pll_rst),
    .sys_reset_n(sys_reset_n),
    .pll_ready(pll_ready),
    .pll_fail(pll_fail),
    .state(state),
    .retry_count(retry_count)
`ifdef SYSTEM_PLL_LOSS_COUNTER_EN
    ,
    .loss_count(loss_count)
`endif
  );

  // Clock and reset-independent timebase
  always #5 clk = ~clk;

  // Advance n active edges, then settle 1 ns past the edge for driving and sampling.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_loss(input string tag, input logic [7:0] exp);
`ifdef SYSTEM_PLL_LOSS_COUNTER_EN
    check_eq(tag, 32'(loss_count), 32'(exp));
`else
    if (exp == 8'hAA) $display("unused %s", tag);
`endif
  endtask

  task automatic pulse_soft();
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    pll_locked     = 1'b0;
    soft_reset_req = 1'b0;
    tick(3);
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_pll_rst", 32'(pll_rst), 1);
    check_eq("rst_sys_reset_n", 32'(sys_reset_n), 0);
    check_eq("rst_pll_ready", 32'(pll_ready), 0);
    check_eq("rst_pll_fail", 32'(pll_fail), 0);
    check_eq("rst_retry", 32'(retry_count), 0);
    check_loss("rst_loss", 8'd0);

    // Scenario 1: normal bring-up, lock raised 10 edges after release
    reset_n = 1'b1;
    tick(3);
    check_eq("s1_pll_rst_e3", 32'(pll_rst), 1);
    tick(1);
    check_eq("s1_pll_rst_e4", 32'(pll_rst), 0);
    check_eq("s1_state_wait", 32'(state), 1);
    tick(6);
    pll_locked = 1'b1;
    tick(2);
    check_eq("s1_state_k1", 32'(state), 1);
    tick(1);
    check_eq("s1_state_stable", 32'(state), 2);
    tick(7);
    check_eq("s1_sys_rst_k9", 32'(sys_reset_n), 0);
    tick(1);
    check_eq("s1_state_run", 32'(state), 3);
    check_eq("s1_sys_rst_k10", 32'(sys_reset_n), 1);
    check_eq("s1_ready", 32'(pll_ready), 1);
    check_eq("s1_pll_rst_run", 32'(pll_rst), 0);

    // Scenario 4: loss of lock in RUN, then relock
    pll_locked = 1'b0;
    tick(2);
    check_eq("s4_still_run", 32'(sys_reset_n), 1);
    tick(1);
    check_eq("s4_sys_rst_drop", 32'(sys_reset_n), 0);
    check_eq("s4_pll_rst_rise", 32'(pll_rst), 1);
    check_eq("s4_state_reset", 32'(state), 0);
    check_loss("s4_loss_inc", 8'd1);
    tick(3);
    check_eq("s4_pll_rst_hold", 32'(pll_rst), 1);
    tick(1);
    check_eq("s4_pll_rst_end", 32'(pll_rst), 0);
    pll_locked = 1'b1;
    tick(10);
    check_eq("s4_relock_stable", 32'(state), 2);
    tick(1);
    check_eq("s4_relock_run", 32'(state), 3);
    check_eq("s4_retry", 32'(retry_count), 0);

    // Scenario 3: one-cycle lock glitch during STABLE
    pulse_soft();
    check_eq("s3_soft_state", 32'(state), 0);
    check_loss("s3_soft_no_loss", 8'd1);
    tick(4);
    check_eq("s3_wait", 32'(state), 1);
    tick(1);
    check_eq("s3_stable", 32'(state), 2);
    tick(3);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    check_eq("s3_stable_cnt5", 32'(state), 2);
    tick(1);
    check_eq("s3_back_wait", 32'(state), 1);
    tick(1);
    check_eq("s3_restable", 32'(state), 2);
    tick(7);
    check_eq("s3_not_yet_run", 32'(state), 2);
    tick(1);
    check_eq("s3_run", 32'(state), 3);
    check_eq("s3_retry", 32'(retry_count), 0);

    // Scenario 6a: lock drop coincident with soft request in RUN
    pll_locked = 1'b0;
    tick(2);
    check_eq("s6_pre_run", 32'(state), 3);
    soft_reset_req = 1'b1;
    tick(1);
    soft_reset_req = 1'b0;
    check_eq("s6_soft_wins", 32'(state), 0);
    check_loss("s6_loss_same", 8'd1);

    // Scenario 2: no lock at all -> FAIL after three attempts
    tick(4);
    check_eq("s2_a1_wait", 32'(state), 1);
    tick(31);
    check_eq("s2_a1_last", 32'(state), 1);
    check_eq("s2_a1_retry", 32'(retry_count), 0);
    tick(1);
    check_eq("s2_a2_reset", 32'(state), 0);
    check_eq("s2_a2_retry", 32'(retry_count), 1);
    check_eq("s2_a2_pll_rst", 32'(pll_rst), 1);
    tick(36);
    check_eq("s2_a3_reset", 32'(state), 0);
    check_eq("s2_a3_retry", 32'(retry_count), 2);
    tick(35);
    check_eq("s2_a3_last", 32'(state), 1);
    tick(1);
    check_eq("s2_fail_state", 32'(state), 4);
    check_eq("s2_fail_flag", 32'(pll_fail), 1);
    check_eq("s2_fail_pll_rst", 32'(pll_rst), 1);
    check_eq("s2_fail_retry", 32'(retry_count), 2);
    check_eq("s2_fail_sys_rst", 32'(sys_reset_n), 0);

    // Scenario 5: FAIL is terminal even with lock; soft request restarts
    pll_locked = 1'b1;
    tick(5);
    check_eq("s5_fail_terminal", 32'(state), 4);
    pulse_soft();
    check_eq("s5_soft_state", 32'(state), 0);
    check_eq("s5_fail_clear", 32'(pll_fail), 0);
    check_eq("s5_retry_clear", 32'(retry_count), 0);
    check_eq("s5_pll_rst", 32'(pll_rst), 1);
    tick(4);
    check_eq("s5_wait", 32'(state), 1);
    tick(1);
    check_eq("s5_stable", 32'(state), 2);
    tick(8);
    check_eq("s5_run", 32'(state), 3);
    check_eq("s5_sys_rst", 32'(sys_reset_n), 1);

    // Timeout coincident with lock on the second attempt, then reset_n mid-STABLE
    pll_locked = 1'b0;
    pulse_soft();
    tick(4);
    check_eq("b_wait", 32'(state), 1);
    tick(32);
    check_eq("b_retry1", 32'(retry_count), 1);
    tick(4);
    check_eq("b_wait2", 32'(state), 1);
    tick(29);
    pll_locked = 1'b1;
    tick(2);
    check_eq("b_wait2_last", 32'(state), 1);
    tick(1);
    check_eq("b_lock_wins", 32'(state), 2);
    check_eq("b_retry_kept", 32'(retry_count), 1);
    tick(2);
    reset_n = 1'b0;
    tick(1);
    check_eq("r_state", 32'(state), 0);
    check_eq("r_retry", 32'(retry_count), 0);
    check_eq("r_pll_rst", 32'(pll_rst), 1);
    check_eq("r_sys_rst", 32'(sys_reset_n), 0);
    check_eq("r_ready", 32'(pll_ready), 0);
    check_eq("r_fail", 32'(pll_fail), 0);
    check_loss("r_loss", 8'd0);
    reset_n = 1'b1;
    tick(3);
    check_eq("r2_pll_rst_e3", 32'(pll_rst), 1);
    tick(1);
    check_eq("r2_pll_rst_e4", 32'(pll_rst), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
